serial_add_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit add or subtract by driving one external 1-bit full-adder cell (s = a^b^ci, co = majority), LSB first, one bit per clock.
- Latches operands on start, shifts them through the cell, accumulates the result, and reports completion with a one-cycle done pulse.
- Sits between a requesting controller and the team's single-bit full-adder cell, which is instantiated alongside it in the parent.

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer for an external
// 1-bit full-adder cell, LSB first, one bit per clock.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start, sub, cin      request, 0=a+b+cin / 1=a-b, add carry-in
//   a, b                 WIDTH-bit operands
//   busy, done           state != IDLE, one-cycle completion pulse
//   sum, cout, ovf       registered result, carry out, signed overflow
//   fa_a, fa_b, fa_ci    to the full-adder cell (0 outside RUN)
//   fa_s, fa_co          from the full-adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNTW-1:0]  r_cnt;

    logic             w_run;
    logic             w_last;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == CNTW'(WIDTH - 1));

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

    assign fa_a  = w_run & r_a[0];
    assign fa_b  = w_run & r_b[0];
    assign fa_ci = w_run & r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                // The edge leaving DONE can also accept a new request,
                // so back-to-back operations issue every WIDTH+1 cycles.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= {fa_s, r_res[WIDTH-1:1]};
                    r_carry <= fa_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= {fa_s, r_res[WIDTH-1:1]};
                        r_cout  <= fa_co;
                        // carry into MSB (fa_ci) vs carry out of MSB
                        r_ovf   <= fa_co ^ fa_ci;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl
// with a behavioural full-adder cell in place of the real one.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;
    logic       fa_a, fa_b, fa_ci, fa_s, fa_co;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    serial_add_ctrl #(.WIDTH(8), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_s(fa_s), .fa_co(fa_co)
    );

    // Issue one request and wait (bounded) for done.
    // lat = cycles from the start edge to the edge that raises done.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub,
                          output int lat, output int busyc,
                          output logic tmo);
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busyc = 0; tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busyc++;
            if (done) begin
                tmo = 1'b0;
                break;
            end
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, cout, ovf, fa_a, fa_b, fa_ci} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=0000000",
                     {busy, done, cout, ovf, fa_a, fa_b, fa_ci});
        end
        n_chk++;
        if (sum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sum got=%h exp=00", sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_op(input string nm, input logic [7:0] ia,
                           input logic [7:0] ib, input logic icin,
                           input logic isub, input logic [7:0] es,
                           input logic ec, input logic eo);
        int lat, bc;
        logic tmo;
        run_op(ia, ib, icin, isub, lat, bc, tmo);
        n_chk++;
        if (tmo) begin
            n_fail++;
            $display("FAIL %s timeout waiting for done", nm);
        end
        n_chk++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL %s_latency got=%0d exp=8", nm, lat);
        end
        n_chk++;
        if (bc !== 9) begin
            n_fail++;
            $display("FAIL %s_busy_cycles got=%0d exp=9", nm, bc);
        end
        n_chk++;
        if ({sum, cout, ovf} !== {es, ec, eo}) begin
            n_fail++;
            $display("FAIL %s_result got=%h/%b/%b exp=%h/%b/%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        n_chk++;
        if ({fa_a, fa_b, fa_ci} !== 3'b0) begin
            n_fail++;
            $display("FAIL %s_fa_in_done got=%b exp=000",
                     nm, {fa_a, fa_b, fa_ci});
        end
        @(negedge clk);
        n_chk++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_after_done got=%b exp=00", nm, {done, busy});
        end
        n_chk++;
        if ({sum, cout, ovf} !== {es, ec, eo}) begin
            n_fail++;
            $display("FAIL %s_hold got=%h/%b/%b exp=%h/%b/%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic tmo;
        @(negedge clk);
        a = 8'h35; b = 8'h4A; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                a = 8'hC3; b = 8'h11; sub = 1'b1; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                tmo = 1'b0;
                break;
            end
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        n_chk++;
        if (tmo || lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_latency got=%0d tmo=%b exp=8", lat, tmo);
        end
        n_chk++;
        if ({sum, cout, ovf} !== {8'h7F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_result got=%h/%b/%b exp=7f/0/0",
                     sum, cout, ovf);
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_not_queued busy=%b exp=0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        @(negedge clk);
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({busy, done} !== 2'b00 || sum !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state got=%b/%h exp=00/00",
                     {busy, done}, sum);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        n_chk++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet got=%0d exp=0", ndone);
        end
        test_op("fresh", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int idx [$];
        int wide, fabad, prev;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        wide = 0; fabad = 0; prev = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                idx.push_back(i);
                if (prev) wide++;
                if ({fa_a, fa_b, fa_ci} !== 3'b0) fabad++;
            end
            prev = done;
        end
        start = 1'b0;
        n_chk++;
        if (idx.size() < 4) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp>=4", idx.size());
        end
        for (int k = 1; k < idx.size(); k++) begin
            n_chk++;
            if (idx[k] - idx[k-1] !== 9) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d] got=%0d exp=9",
                         k, idx[k] - idx[k-1]);
            end
        end
        n_chk++;
        if (wide !== 0 || fabad !== 0) begin
            n_fail++;
            $display("FAIL b2b_done_shape wide=%0d fa=%0d exp=0/0",
                     wide, fabad);
        end
        n_chk++;
        if (sum !== 8'h03) begin
            n_fail++;
            $display("FAIL b2b_sum got=%h exp=03", sum);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        test_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        test_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        test_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        test_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        test_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
